multi_button_toggle: RTL
========================

Name: multi_button_toggle

Overview:
- Parametrised N-channel push-button front end: per channel, 2-FF synchroniser, counter-based debounce, press/long-press pulse generation and a latched output state.
- Per-channel run-time mode: toggle on press, momentary (follow button), or toggle on long press.
- Sits between board push-buttons and user logic (LED drivers, mode selects); replaces single-channel button-plus-T-flip-flop pairs.

Parameters:
- N, 4, number of button channels (>=1).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (>=2).
- LONG_CYCLES, 50000000, cycles the debounced press must be held for a long-press event (>=2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- in  input  N  raw asynchronous button levels, 1 = pressed.
- mode  input  2*N  per-channel mode, channel i at bits [2i+1:2i]; 00 toggle, 01 momentary, 10 long-toggle, 11 treated as 00.
- clear  input  1  synchronous clear of all latched states.
- out  output  N  per-channel output state.
- press_pulse  output  N  one-cycle pulse on each accepted press.
- long_pulse  output  N  one-cycle pulse when a press reaches LONG_CYCLES.
- level  output  N  debounced button level.

Behaviour:
- Reset (reset=0, asynchronous): synchroniser FFs, level, counters, out, press_pulse and long_pulse all cleared to 0.
- Synchroniser: s1 <= in, s2 <= s1. All later logic uses s2 only.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES).
  - If s2 == level: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: level <= s2, counter <= 0.
  - Else: counter increments.
  - Any bounce back to the old level restarts the count.
- Latency: raw change first sampled at edge 1 updates level at edge 2+DEBOUNCE_CYCLES.
- press_pulse: registered; goes high on the same edge that level goes 0->1, for exactly one cycle. A release produces no pulse.
- Hold counter: width $clog2(LONG_CYCLES).
  - Counts while level=1; cleared when level=0.
  - Saturates at LONG_CYCLES-1.
  - long_pulse is registered and goes high for one cycle on the edge after the counter reaches LONG_CYCLES-1 with level still 1.
  - At most one long_pulse per press; holding longer gives nothing more.
- out update each cycle, priority order:
  1. clear=1: out <= 0 for all channels (wins over a simultaneous toggle).
  2. Mode 01: out <= level.
  3. Mode 00 or 11: out <= out ^ press_pulse (toggles the edge after press_pulse).
  4. Mode 10: out <= out ^ long_pulse.
- Mode change mid-operation:
  - out is held from the prior mode and is not reset.
  - A pulse coincident with the change is interpreted under the new mode.
  - Debounce and hold counters are unaffected by mode.
- Channels are fully independent; simultaneous events on several channels are all honoured in the same cycle.
- Reset mid-press: all state drops to 0. A button still held after reset release is re-debounced and gives a fresh press_pulse.
- No combinational path from any input to any output.

Decomposition:
- Shared package multi_button_pkg holds:
  - Mode constants: MODE_TOGGLE=2'b00, MODE_MOMENTARY=2'b01, MODE_LONG=2'b10.
  - A clog2-based width helper.
- Sub-module button_channel holds everything for one channel: sync, debounce, hold counter, pulses and out logic.
- Top level instantiates N copies in a generate loop and slices mode and the output buses.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=16, N=4):
- Clean press, mode 00: in[0] rises before edge 1 and held → level[0] and press_pulse[0] high after edge 6, press_pulse low after edge 7, out[0]=1 after edge 7; release then second press → out[0]=0.
- Bounce: in[1] toggles high 2 cycles, low 1, high 2, low → level[1], press_pulse[1] and out[1] stay 0 throughout.
- Long press, mode 10: in[2] held 30 cycles → press_pulse[2] after edge 6 with out[2] unchanged; long_pulse[2] single cycle after edge 22; out[2]=1 after edge 23; no further pulse while held.
- Momentary, mode 01: in[3] held 10 cycles then released → out[3] high from edge 6, low at edge 2+4 after release is sampled; matches level[3].
- clear coincident with press_pulse[0] while out[0]=1 → out[0]=0, not toggled back to 1; other channels in mode 00 also cleared.
- Asynchronous reset asserted mid-debounce and again while out=4'b1111 → all outputs 0 immediately, without a clock edge. After release with buttons still held → fresh press_pulse after 2+DEBOUNCE_CYCLES edges.

Source files
------------

// File: rtl/multi_button_toggle_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multi_button_pkg                                           |
// | Description : Shared constants and helpers for the multi-channel         |
// |               push-button front end.                                     |
// |               - Per-channel mode encodings.                              |
// |               - Counter width helper.                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package multi_button_pkg;

   // Per-channel mode encodings. 2'b11 is not listed; it behaves as toggle.
   localparam logic [1:0] MODE_TOGGLE    = 2'b00;
   localparam logic [1:0] MODE_MOMENTARY = 2'b01;
   localparam logic [1:0] MODE_LONG      = 2'b10;

   // Width of a counter that must hold values 0 .. value-1.
   // The result is never below 1, so small parameters still give a legal vector.
   function automatic int cnt_width(input int value);
      int w;
      w = $clog2(value);
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multi_button_toggle_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : button_channel                                             |
// | Description : One push-button channel.                                   |
// |               - 2-FF synchroniser.                                       |
// |               - Counter debounce.                                        |
// |               - Press / long-press pulses.                               |
// |               - Latched output state.                                    |
// | Ports       : clk, reset (async, active-low), in (raw button),           |
// |               mode[1:0], clear -> out, press_pulse, long_pulse, level    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module button_channel
   import multi_button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       in,
   input  logic [1:0] mode,
   input  logic       clear,
   output logic       out,
   output logic       press_pulse,
   output logic       long_pulse,
   output logic       level
);

   localparam int                  c_DB_W     = cnt_width(DEBOUNCE_CYCLES);
   localparam int                  c_HOLD_W   = cnt_width(LONG_CYCLES);
   localparam logic [c_DB_W-1:0]   c_DB_MAX   = c_DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_DB_W-1:0]   c_DB_ONE   = c_DB_W'(1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(LONG_CYCLES - 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);

   logic                r_s1;
   logic                r_s2;
   logic [c_DB_W-1:0]   r_db_cnt;
   logic                r_level;
   logic [c_HOLD_W-1:0] r_hold_cnt;
   logic                r_long_done;
   logic                r_press;
   logic                r_long;
   logic                r_out;

   logic                w_db_done;
   logic                w_level_nxt;

   // The synchronised level has differed from the debounced level long enough.
   assign w_db_done   = (r_s2 != r_level) && (r_db_cnt == c_DB_MAX);
   // Debounced level as it will be after this edge; momentary mode follows it
   // so that out and level change on the same edge.
   assign w_level_nxt = w_db_done ? r_s2 : r_level;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1        <= 1'b0;
         r_s2        <= 1'b0;
         r_db_cnt    <= '0;
         r_level     <= 1'b0;
         r_hold_cnt  <= '0;
         r_long_done <= 1'b0;
         r_press     <= 1'b0;
         r_long      <= 1'b0;
         r_out       <= 1'b0;
      end else begin
         r_s1 <= in;
         r_s2 <= r_s1;

         // Any return to the accepted level restarts the stability count.
         if (r_s2 == r_level) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == c_DB_MAX) begin
            r_level  <= r_s2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + c_DB_ONE;
         end

         // Only a 0->1 acceptance is a press; releases are silent.
         r_press <= w_db_done & r_s2;

         // Hold counter saturates; r_long_done limits each press to one pulse.
         if (!r_level) begin
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_long      <= 1'b0;
         end else begin
            if (r_hold_cnt != c_HOLD_MAX) begin
               r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
            end
            r_long <= (r_hold_cnt == c_HOLD_MAX) && !r_long_done;
            if (r_hold_cnt == c_HOLD_MAX) begin
               r_long_done <= 1'b1;
            end
         end

         // Mode is sampled live, so a pulse arriving with a mode change is
         // handled by the new mode while out keeps its previous value.
         if (clear) begin
            r_out <= 1'b0;
         end else begin
            case (mode)
               MODE_MOMENTARY: r_out <= w_level_nxt;
               MODE_LONG:      r_out <= r_out ^ r_long;
               default:        r_out <= r_out ^ r_press;
            endcase
         end
      end
   end

   assign out         = r_out;
   assign press_pulse = r_press;
   assign long_pulse  = r_long;
   assign level       = r_level;

endmodule
`default_nettype wire

// File: rtl/multi_button_toggle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multi_button_toggle                                        |
// | Description : N independent debounced push-button channels, each with   |
// |               its own toggle / momentary / long-toggle mode.             |
// | Ports       : clk, reset (async, active-low), in[N], mode[2N] (channel i |
// |               at [2i+1:2i]), clear -> out[N], press_pulse[N],            |
// |               long_pulse[N], level[N]                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multi_button_toggle
   import multi_button_pkg::*;
#(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000
)(
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   in,
   input  logic [2*N-1:0] mode,
   input  logic           clear,
   output logic [N-1:0]   out,
   output logic [N-1:0]   press_pulse,
   output logic [N-1:0]   long_pulse,
   output logic [N-1:0]   level
);

   for (genvar g = 0; g < N; g++) begin : g_chan
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_chan (
         .clk         (clk),
         .reset       (reset),
         .in          (in[g]),
         .mode        (mode[2*g +: 2]),
         .clear       (clear),
         .out         (out[g]),
         .press_pulse (press_pulse[g]),
         .long_pulse  (long_pulse[g]),
         .level       (level[g])
      );
   end

endmodule
`default_nettype wire
